// File: rtl/data_mem_responder_pkg.sv
// Shared access-mode encodings, MMIO register offsets and FSM state type
// for the CPU data-side memory responder.
package data_mem_responder_pkg;

  localparam int unsigned MMD_W = 3;

  localparam logic [MMD_W-1:0] MM_WORD  = 3'd0;
  localparam logic [MMD_W-1:0] MM_HALF  = 3'd1;
  localparam logic [MMD_W-1:0] MM_HALFU = 3'd2;
  localparam logic [MMD_W-1:0] MM_BYTE  = 3'd3;
  localparam logic [MMD_W-1:0] MM_BYTEU = 3'd4;

  localparam logic [3:0] MMIO_CYC  = 4'h0;
  localparam logic [3:0] MMIO_STC  = 4'h4;
  localparam logic [3:0] MMIO_STAT = 4'h8;
  localparam logic [3:0] MMIO_GPIO = 4'hC;

  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} respState_e;

  typedef enum logic [1:0] {SZ_BYTE = 2'd0, SZ_HALF = 2'd1, SZ_WORD = 2'd2} accSize_e;

  // Unused codes 5-7 fall back to word accesses.
  function automatic accSize_e modeSize(input logic [MMD_W-1:0] mode);
    case (mode)
      MM_WORD:           return SZ_WORD;
      MM_HALF, MM_HALFU: return SZ_HALF;
      MM_BYTE, MM_BYTEU: return SZ_BYTE;
      default:           return SZ_WORD;
    endcase
  endfunction

  function automatic logic modeSigned(input logic [MMD_W-1:0] mode);
    return (mode == MM_HALF) || (mode == MM_BYTE);
  endfunction

endpackage

// File: rtl/data_mem_responder_lane_align.sv
// Little-endian lane steering: byte enables and replicated store data on the
// write side, lane extraction with sign/zero extension on the read side.
module mem_lane_align
  import data_mem_responder_pkg::*;
(
  input  logic [1:0]       addrLo,
  input  logic [MMD_W-1:0] mode,
  input  logic [31:0]      storeData,
  input  logic [31:0]      rdWord,
  output logic [3:0]       byteEn_c,
  output logic [31:0]      storeLanes_c,
  output logic [31:0]      loadData_c
);

  logic       sgn;
  logic [7:0]  laneByte;
  logic [15:0] laneHalf;

  always_comb begin
    byteEn_c     = 4'b1111;
    storeLanes_c = storeData;
    loadData_c   = rdWord;
    laneByte     = rdWord[{addrLo, 3'b000} +: 8];
    laneHalf     = addrLo[1] ? rdWord[31:16] : rdWord[15:0];
    sgn          = modeSigned(mode);
    case (modeSize(mode))
      SZ_BYTE: begin
        byteEn_c     = 4'b0001 << addrLo;
        storeLanes_c = {4{storeData[7:0]}};
        loadData_c   = {{24{sgn & laneByte[7]}}, laneByte};
      end
      SZ_HALF: begin
        byteEn_c     = addrLo[1] ? 4'b1100 : 4'b0011;
        storeLanes_c = {2{storeData[15:0]}};
        loadData_c   = {{16{sgn & laneHalf[15]}}, laneHalf};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// CPU data-port target: word RAM with byte/half/word access, power-up clear,
// sticky access-error capture and a four-register MMIO window.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      dataAddress,
  input  logic [31:0]      writeMemData,
  input  logic             memRead,
  input  logic             memWrite,
  input  logic [MMD_W-1:0] memMode,
  output logic [31:0]      readMemData,
  output logic             initDone,
  output logic             errSticky,
  output logic [31:0]      errAddr,
  output logic [31:0]      gpioOut
);

  localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);

  logic [31:0] mem [DEPTH_WORDS];

  respState_e       state, nextState;
  logic [IDX_W-1:0] clrIdx, nextClrIdx;
  logic             clrWr;
  logic [31:0]      cycleCnt, storeCnt;

  logic             running, active, ramHit, mmioHit, misaligned, accErr;
  logic             storeOk, ramWr, mmioWr, statWrAttempt;
  accSize_e         accSize;
  logic [IDX_W-1:0] wordIdx;
  logic [31:0]      mmioWord, rdWord;
  logic [3:0]       byteEn;
  logic [31:0]      storeLanes, loadData;

  // Request decode and fault classification
  assign running    = (state == RUN);
  assign active     = running && (memRead || memWrite);
  assign wordIdx    = dataAddress[IDX_W+1:2];
  assign ramHit     = dataAddress < RAM_BYTES;
  assign mmioHit    = dataAddress[31:4] == MMIO_BASE[31:4];
  assign accSize    = modeSize(memMode);
  assign misaligned = ((accSize == SZ_HALF) && dataAddress[0]) ||
                      ((accSize == SZ_WORD) && (dataAddress[1:0] != 2'b00));
  assign accErr     = active && (misaligned || !(ramHit || mmioHit) ||
                                 (mmioHit && (accSize != SZ_WORD)));

  assign storeOk       = rst_n && running && memWrite && !accErr;
  assign ramWr         = storeOk && ramHit;
  assign mmioWr        = storeOk && mmioHit && !ramHit;
  assign statWrAttempt = running && memWrite && mmioHit &&
                         (dataAddress[3:2] == MMIO_STAT[3:2]);

  always_comb begin
    mmioWord = '0;
    case (dataAddress[3:0])
      MMIO_CYC:  mmioWord = cycleCnt;
      MMIO_STC:  mmioWord = storeCnt;
      MMIO_STAT: mmioWord = {30'b0, initDone, errSticky};
      MMIO_GPIO: mmioWord = gpioOut;
      default:   mmioWord = '0;
    endcase
  end

  assign rdWord = ramHit ? mem[wordIdx] : mmioWord;

  mem_lane_align u_align (
    .addrLo       (dataAddress[1:0]),
    .mode         (memMode),
    .storeData    (writeMemData),
    .rdWord       (rdWord),
    .byteEn_c     (byteEn),
    .storeLanes_c (storeLanes),
    .loadData_c   (loadData)
  );

  assign readMemData = (rst_n && running && memRead && !accErr) ? loadData : '0;
  assign initDone    = running;

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= CLEAR;
      clrIdx <= '0;
    end else begin
      state  <= nextState;
      clrIdx <= nextClrIdx;
    end
  end

  // Clear sweeps one word per cycle, then hands over to RUN
  always_comb begin
    nextState  = state;
    nextClrIdx = clrIdx;
    clrWr      = 1'b0;
    case (state)
      CLEAR: begin
        clrWr      = 1'b1;
        nextClrIdx = clrIdx + IDX_W'(1);
        if (clrIdx == IDX_W'(DEPTH_WORDS - 1)) nextState = RUN;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n && clrWr) begin
      mem[clrIdx] <= '0;
    end else if (ramWr) begin
      for (int b = 0; b < 4; b++) begin
        if (byteEn[b]) mem[wordIdx][8*b +: 8] <= storeLanes[8*b +: 8];
      end
    end
  end

  // Counters, GPIO and error capture; a fault outranks a status clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycleCnt  <= '0;
      storeCnt  <= '0;
      gpioOut   <= '0;
      errSticky <= 1'b0;
      errAddr   <= '0;
    end else begin
      cycleCnt <= cycleCnt + 32'd1;
      if (ramWr) storeCnt <= storeCnt + 32'd1;
      if (mmioWr && (dataAddress[3:0] == MMIO_GPIO)) gpioOut <= writeMemData;
      if (accErr) begin
        errSticky <= 1'b1;
        if (!errSticky || statWrAttempt) errAddr <= dataAddress;
      end else if (statWrAttempt) begin
        errSticky <= 1'b0;
        errAddr   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: driver predicts each cycle from a
// byte-addressed reference model, monitor compares on the falling edge.
module tb_data_mem_responder;
  import data_mem_responder_pkg::*;

  localparam int unsigned DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'hFFFF_0000;

  logic        clk, rst_n;
  logic [31:0] dataAddress, writeMemData;
  logic        memRead, memWrite;
  logic [2:0]  memMode;
  logic [31:0] readMemData;
  logic        initDone, errSticky;
  logic [31:0] errAddr, gpioOut;

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .MMIO_BASE(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .dataAddress(dataAddress), .writeMemData(writeMemData),
    .memRead(memRead), .memWrite(memWrite), .memMode(memMode),
    .readMemData(readMemData), .initDone(initDone), .errSticky(errSticky),
    .errAddr(errAddr), .gpioOut(gpioOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] rd;
    logic [31:0] errA;
    logic [31:0] gpio;
    bit          errS;
    bit          init;
  } exp_t;

  exp_t expQ[$];
  int   nChecks = 0;
  int   nFails  = 0;

  // Reference model state
  byte unsigned ramB [DEPTH*4];
  logic [31:0]  mCyc, mStc, mGpio, mErrA;
  bit           mErrS;
  int           mSinceRst;

  function automatic void modelReset();
    foreach (ramB[i]) ramB[i] = 8'h00;
    mCyc = '0; mStc = '0; mGpio = '0; mErrA = '0; mErrS = 1'b0; mSinceRst = 0;
  endfunction

  function automatic void chk(input string tag, input string what,
                              input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s %s: got %h expected %h (t=%0t)", tag, what, act, exp, $time);
    end
  endfunction

  // One bus cycle: drive, predict outputs for this cycle, advance the model
  task automatic cyc(input bit rstv, input bit rd, input bit wr, input logic [2:0] mode,
                     input logic [31:0] addr, input logic [31:0] data, input string tag,
                     input bit useDir = 1'b0, input logic [31:0] dirRd = 32'h0);
    exp_t        e;
    int          size;
    bit          sgn, init, inRam, inMmio, act, err, isStat, oldErrS;
    logic [31:0] v, off;
    @(posedge clk);
    #1;
    rst_n = rstv; memRead = rd; memWrite = wr; memMode = mode;
    dataAddress = addr; writeMemData = data;

    size   = (mode == 3'd1 || mode == 3'd2) ? 2 : (mode == 3'd3 || mode == 3'd4) ? 1 : 4;
    sgn    = (mode == 3'd1 || mode == 3'd3);
    init   = (mSinceRst >= DEPTH);
    inRam  = (longint'(addr) < longint'(DEPTH * 4));
    inMmio = (addr >= BASE) && (addr <= BASE + 32'd15);
    off    = addr - BASE;
    act    = rstv && init && (rd || wr);
    err    = act && ((addr % size) != 0 || !(inRam || inMmio) || (inMmio && size != 4));

    v = '0;
    if (inRam) begin
      for (int k = 0; k < size; k++) v = v | (32'(ramB[addr + k]) << (8 * k));
      if (sgn && v[8*size-1]) v = v | ~((32'd1 << (8 * size)) - 32'd1);
    end else if (inMmio) begin
      case (off)
        32'd0:   v = mCyc;
        32'd4:   v = mStc;
        32'd8:   v = {30'b0, init, mErrS};
        32'd12:  v = mGpio;
        default: v = '0;
      endcase
    end

    e.tag  = tag;
    e.rd   = useDir ? dirRd : ((rstv && init && rd && !err) ? v : 32'h0);
    e.errS = mErrS; e.errA = mErrA; e.gpio = mGpio; e.init = init;
    expQ.push_back(e);

    if (!rstv) begin
      modelReset();
    end else begin
      oldErrS = mErrS;
      isStat  = act && wr && inMmio && (off >> 2) == 32'd2;
      if (err) begin
        mErrS = 1'b1;
        if (!oldErrS || isStat) mErrA = addr;
      end else if (isStat) begin
        mErrS = 1'b0;
        mErrA = '0;
      end
      if (act && wr && !err) begin
        if (inRam) begin
          for (int k = 0; k < size; k++) ramB[addr + k] = 8'(data >> (8 * k));
          mStc = mStc + 32'd1;
        end else if (off == 32'd12) begin
          mGpio = data;
        end
      end
      mCyc = mCyc + 32'd1;
      if (mSinceRst < DEPTH) mSinceRst++;
    end
  endtask

  task automatic clearPhase(input string tag);
    for (int i = 0; i < DEPTH; i++)
      cyc(1'b1, 1'($urandom), 1'($urandom), 3'($urandom_range(0, 7)),
          32'($urandom_range(0, 255)), $urandom, tag);
  endtask

  // Monitor: one expectation per driven cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        chk(e.tag, "readMemData", readMemData, e.rd);
        chk(e.tag, "initDone", 32'(initDone), 32'(e.init));
        chk(e.tag, "errSticky", 32'(errSticky), 32'(e.errS));
        chk(e.tag, "errAddr", errAddr, e.errA);
        chk(e.tag, "gpioOut", gpioOut, e.gpio);
      end
    end
  end

  initial begin
    logic [31:0] a;
    int          sel;
    rst_n = 1'b0; memRead = 1'b0; memWrite = 1'b0; memMode = MM_WORD;
    dataAddress = '0; writeMemData = '0;
    modelReset();
    repeat (3) @(posedge clk);

    clearPhase("clear");
    cyc(1, 1, 0, MM_WORD, BASE + 32'h0, 0, "cyc_at_init", 1, 32'(DEPTH));

    cyc(1, 0, 1, MM_WORD,  32'h10, 32'h8899AABB, "sw10");
    cyc(1, 1, 0, MM_BYTE,  32'h11, 0, "lb11",  1, 32'hFFFFFFAA);
    cyc(1, 1, 0, MM_BYTEU, 32'h11, 0, "lbu11", 1, 32'h000000AA);
    cyc(1, 1, 0, MM_HALF,  32'h12, 0, "lh12",  1, 32'hFFFF8899);
    cyc(1, 1, 0, MM_HALFU, 32'h12, 0, "lhu12", 1, 32'h00008899);
    cyc(1, 1, 1, MM_BYTE,  32'h13, 32'h5A, "sb13_rd_old", 1, 32'hFFFFFF88);
    cyc(1, 1, 0, MM_WORD,  32'h10, 0, "lw10", 1, 32'h5A99AABB);
    cyc(1, 1, 0, MM_WORD,  BASE + 32'h4, 0, "storecnt", 1, 32'd2);

    cyc(1, 1, 0, MM_WORD, 32'h6, 0, "lw_misaligned", 1, 32'h0);
    cyc(1, 0, 1, MM_HALF, 32'h9, 32'h1234, "sh_misaligned");
    cyc(1, 1, 0, MM_WORD, 32'h8, 0, "lw8_untouched", 1, 32'h0);
    cyc(1, 0, 1, MM_WORD, BASE + 32'h8, 0, "status_clear");
    cyc(1, 1, 0, MM_WORD, BASE + 32'h8, 0, "status_rd", 1, 32'h2);

    cyc(1, 0, 1, MM_WORD, BASE + 32'hC, 32'hDEADBEEF, "gpio_wr");
    cyc(1, 1, 0, MM_WORD, BASE + 32'hC, 0, "gpio_rd", 1, 32'hDEADBEEF);
    cyc(1, 0, 1, MM_BYTE, BASE + 32'hC, 32'h11, "gpio_sb");
    cyc(1, 1, 0, MM_WORD, BASE + 32'hC, 0, "gpio_rd2", 1, 32'hDEADBEEF);
    cyc(1, 0, 1, MM_BYTE, BASE + 32'h8, 32'h1, "status_sb_fault");
    cyc(1, 1, 0, MM_WORD, 32'hFFC, 0, "lw_last_word");
    cyc(1, 1, 0, MM_WORD, 32'h1000, 0, "lw_past_end", 1, 32'h0);

    // Randomised traffic across RAM, edges, MMIO and unmapped space
    for (int i = 0; i < 800; i++) begin
      sel = $urandom_range(0, 15);
      if (sel < 10) begin
        a = 32'($urandom_range(0, 63) * 4);
        if ($urandom_range(0, 3) == 0) a = a + 32'($urandom_range(0, 3));
      end else if (sel == 10) begin
        a = 32'hFFC + 32'($urandom_range(0, 5));
      end else if (sel < 13) begin
        a = BASE + 32'($urandom_range(0, 3) * 4);
      end else if (sel == 13) begin
        a = 32'h2000 + $urandom_range(0, 32'h0FFF_FFFF);
      end else begin
        a = BASE + 32'h8;
      end
      if (sel >= 14)
        cyc(1, 1'($urandom), 1, MM_WORD, a, $urandom, "rand_stat");
      else
        cyc(1, 1'($urandom), 1'($urandom), 3'($urandom_range(0, 7)), a, $urandom, "rand");
    end

    cyc(1, 0, 1, MM_WORD, BASE + 32'hC, 32'h0BAD_F00D, "gpio_pre_rst");
    cyc(1, 0, 1, MM_WORD, 32'h40, 32'hCAFEF00D, "sw40");
    cyc(1, 1, 0, MM_WORD, 32'h40, 0, "lw40", 1, 32'hCAFEF00D);
    cyc(0, 1, 0, MM_WORD, 32'h40, 0, "in_reset", 1, 32'h0);
    clearPhase("reclear");
    cyc(1, 1, 0, MM_WORD, BASE + 32'h0, 0, "cyc_after_reclear", 1, 32'(DEPTH));
    cyc(1, 1, 0, MM_WORD, 32'h40, 0, "lw40_cleared", 1, 32'h0);
    cyc(1, 1, 0, MM_WORD, BASE + 32'h4, 0, "storecnt_reset", 1, 32'h0);
    cyc(1, 1, 0, MM_WORD, BASE + 32'hC, 0, "gpio_reset", 1, 32'h0);
    cyc(1, 0, 0, MM_WORD, 32'h0, 0, "idle");

    repeat (3) @(negedge clk);
    chk("drain", "pending", 32'(expQ.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
